// File: rtl/mdio_master.sv
// MDIO (clause 22) management master: serialises one read or write frame per
// accepted request, generates MDC, and captures read data from the PHY.
module mdio_master #(
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter int         HALF_PERIOD   = 1,
  parameter int         PREAMBLE_BITS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic        rd_request,
  input  logic        wr_request,
  input  logic [15:0] wr_data,
  output logic        ready,
  output logic [15:0] rd_data,
  inout  wire         mdio_pin,
  output logic        mdc_pin
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_HEADER   = 3'd2,
    S_TA       = 3'd3,
    S_DATA     = 3'd4
  } state_e;

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BITS - 1);

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  hp_cnt_q, hp_cnt_d;
  logic        mdc_q, mdc_d;
  logic        is_write_q, is_write_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] rd_data_q, rd_data_d;

  logic        mdio_oe;
  logic        mdio_out;
  logic [13:0] header;
  logic [5:0]  last_bit;
  state_e      after_state;

  assign header  = {2'b01, (is_write_q ? 2'b01 : 2'b10), PHY_ADDR, addr_q};
  assign ready   = (state_q == S_IDLE) && !rd_request && !wr_request;
  assign mdc_pin = mdc_q;
  assign rd_data = rd_data_q;

  // The driven bit depends only on state and bit index, so it can only change
  // at a bit boundary, which is always the start of an MDC low phase.
  always_comb begin
    mdio_oe  = 1'b0;
    mdio_out = 1'b0;
    case (state_q)
      S_PREAMBLE: begin
        mdio_oe  = 1'b1;
        mdio_out = 1'b1;
      end
      S_HEADER: begin
        mdio_oe  = 1'b1;
        mdio_out = header[4'(6'd13 - bit_cnt_q)];
      end
      S_TA: begin
        mdio_oe  = is_write_q;
        mdio_out = ~bit_cnt_q[0];
      end
      S_DATA: begin
        mdio_oe  = is_write_q;
        mdio_out = wr_data_q[4'(6'd15 - bit_cnt_q)];
      end
      default: ;
    endcase
  end

  assign mdio_pin = mdio_oe ? mdio_out : 1'bz;

  always_comb begin
    last_bit    = 6'd0;
    after_state = S_IDLE;
    case (state_q)
      S_PREAMBLE: begin last_bit = PRE_LAST; after_state = S_HEADER; end
      S_HEADER:   begin last_bit = 6'd13;    after_state = S_TA;     end
      S_TA:       begin last_bit = 6'd1;     after_state = S_DATA;   end
      S_DATA:     begin last_bit = 6'd15;    after_state = S_IDLE;   end
      default: ;
    endcase
  end

  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hp_cnt_d   = hp_cnt_q;
    mdc_d      = mdc_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        mdc_d     = 1'b0;
        hp_cnt_d  = 8'd0;
        bit_cnt_d = 6'd0;
        if (wr_request || rd_request) begin
          is_write_d = wr_request;
          addr_d     = addr;
          wr_data_d  = wr_data;
          state_d    = (PREAMBLE_BITS == 0) ? S_HEADER : S_PREAMBLE;
        end
      end
      S_PREAMBLE, S_HEADER, S_TA, S_DATA: begin
        if (hp_cnt_q != HP_LAST) begin
          hp_cnt_d = hp_cnt_q + 8'd1;
        end else begin
          hp_cnt_d = 8'd0;
          mdc_d    = ~mdc_q;
          if (!mdc_q) begin
            if (state_q == S_DATA && !is_write_q)
              shift_d = {shift_q[14:0], mdio_pin};
          end else if (bit_cnt_q == last_bit) begin
            bit_cnt_d = 6'd0;
            state_d   = after_state;
            if (state_q == S_DATA && !is_write_q)
              rd_data_d = shift_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        mdc_d     = 1'b0;
        hp_cnt_d  = 8'd0;
        bit_cnt_d = 6'd0;
      end
    endcase
  end

  // NOTE: non-blocking assignments make every flop update from the values of
  // the previous cycle, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 6'd0;
      hp_cnt_q   <= 8'd0;
      mdc_q      <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= 5'd0;
      wr_data_q  <= 16'h0000;
      shift_q    <= 16'h0000;
      rd_data_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hp_cnt_q   <= hp_cnt_d;
      mdc_q      <= mdc_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: a PHY model on a pulled-up MDIO line,
// a bit-level frame model, and directed plus randomized request sequences.
module tb_mdio_master;

  localparam logic [4:0] PHY       = 5'd0;
  localparam int         HP        = 1;
  localparam int         PB        = 32;
  localparam int         NBITS     = PB + 32;
  localparam int         FRAME_CYC = NBITS * 2 * HP;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        rd_request;
  logic        wr_request;
  logic [15:0] wr_data;
  logic        ready;
  logic [15:0] rd_data;
  logic        mdc_pin;
  wire         mdio;

  logic        phy_read = 1'b0;
  logic        phy_oe   = 1'b0;
  logic        phy_out  = 1'b0;
  logic [15:0] phy_word = 16'h0000;

  int checks = 0;
  int errors = 0;
  bit got[$];
  logic [15:0] exp_rd = 16'h0000;

  assign mdio = (phy_read && phy_oe) ? phy_out : 1'bz;
  pullup (mdio);

  mdio_master #(.PHY_ADDR(PHY), .HALF_PERIOD(HP), .PREAMBLE_BITS(PB)) dut (
    .clock      (clock),
    .reset      (reset),
    .addr       (addr),
    .rd_request (rd_request),
    .wr_request (wr_request),
    .wr_data    (wr_data),
    .ready      (ready),
    .rd_data    (rd_data),
    .mdio_pin   (mdio),
    .mdc_pin    (mdc_pin)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Line monitor and PHY: records the line on each MDC rise, and on each MDC
  // fall drives TA2 and the read payload when a read frame is in progress.
  initial begin : monitor
    bit prev = 1'b0;
    int b;
    forever begin
      @(negedge clock);
      if (!phy_read) phy_oe = 1'b0;
      if (mdc_pin && !prev) got.push_back(mdio);
      if (!mdc_pin && prev) begin
        b = got.size();
        phy_oe = (b >= PB + 15) && (b <= PB + 31);
        if (b == PB + 15) phy_out = 1'b0;
        else if (b >= PB + 16 && b <= PB + 31) phy_out = phy_word[4'(PB + 31 - b)];
      end
      prev = mdc_pin;
    end
  end

  task automatic run_frame(input bit wr, input bit rd, input logic [4:0] a,
                           input logic [15:0] wd, input logic [15:0] pw,
                           input int rst_cycles, input int pulse_at, input int abort_at);
    bit              is_wr;
    bit              exp_bits[$];
    logic [4:0]      pa;
    logic [NBITS-1:0] ev, gv;
    int              cycles;
    int              n;
    is_wr = wr;
    pa    = PHY;
    for (int i = 0; i < PB; i++) exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
    exp_bits.push_back(!is_wr); exp_bits.push_back(is_wr);
    for (int i = 4; i >= 0; i--) exp_bits.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) exp_bits.push_back(a[i]);
    // Write drives 1,0; a read shows the pull-up then the PHY's 0.
    exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
    for (int i = 15; i >= 0; i--) exp_bits.push_back(is_wr ? wd[i] : pw[i]);

    addr = a; wr_data = wd; phy_word = pw;
    if (rst_cycles > 0) begin
      got.delete();
      phy_read = !is_wr;
      reset = 1'b1; wr_request = wr; rd_request = rd;
      repeat (rst_cycles) begin
        @(negedge clock);
        check("rst_mdc", mdc_pin, 0);
        check("rst_ready", ready, 0);
      end
      check("rst_nobits", got.size(), 0);
      reset = 1'b0;
    end else begin
      n = 0;
      while (!ready && n < 2000) begin @(negedge clock); n++; end
      check("ready_wait", ready, 1);
      got.delete();
      phy_read = !is_wr;
      wr_request = wr; rd_request = rd;
      #1 check("ready_drop", ready, 0);
    end
    @(posedge clock);
    #1 wr_request = 1'b0; rd_request = 1'b0;

    cycles = 0;
    while (cycles < 1000) begin
      @(negedge clock);
      if (ready) break;
      cycles++;
      if (pulse_at > 0) rd_request = (cycles == pulse_at);
      if (cycles == abort_at) begin
        reset = 1'b1; phy_read = 1'b0;
        @(posedge clock);
        #1;
        check("abort_mdc", mdc_pin, 0);
        check("abort_mdio", mdio, 1);
        check("abort_rd_data", rd_data, 16'h0000);
        check("abort_ready", ready, 1);
        exp_rd = 16'h0000;
        reset = 1'b0;
        return;
      end
    end
    check("busy_cycles", cycles, FRAME_CYC);
    check("nbits", got.size(), NBITS);
    for (int i = 0; i < NBITS; i++) begin
      ev[NBITS-1-i] = exp_bits[i];
      gv[NBITS-1-i] = (i < got.size()) ? got[i] : 1'b0;
    end
    check("frame_bits", gv, ev);
    if (!is_wr) exp_rd = pw;
    check("rd_data", rd_data, exp_rd);
    if (pulse_at > 0) begin
      repeat (10) @(negedge clock);
      check("busy_ignored_bits", got.size(), NBITS);
      check("busy_ignored_ready", ready, 1);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit w, r;
    reset = 1'b1; rd_request = 1'b0; wr_request = 1'b0;
    addr = 5'd0; wr_data = 16'h0000;
    repeat (3) @(negedge clock);
    check("reset_ready", ready, 1);
    check("reset_mdc", mdc_pin, 0);
    check("reset_mdio", mdio, 1);
    check("reset_rd_data", rd_data, 16'h0000);

    // Write request held through reset, accepted on the first free cycle.
    run_frame(1'b1, 1'b0, 5'h0d, 16'h0002, 16'h0000, 3, 0, 0);
    run_frame(1'b0, 1'b1, 5'd31, 16'h0000, 16'h0064, 0, 0, 0);
    run_frame(1'b1, 1'b1, 5'd0, 16'h1300, 16'hbeef, 0, 0, 0);
    run_frame(1'b1, 1'b0, 5'($urandom), 16'($urandom), 16'h0000, 0, 40, 0);
    run_frame(1'b0, 1'b1, 5'h0a, 16'h0000, 16'($urandom), 0, 0, 100);
    check("post_abort_rd_data", rd_data, 16'h0000);

    // Back-to-back handshake: 19 writes then a read.
    for (int i = 0; i < 20; i++)
      run_frame(i < 19, i == 19, 5'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      w = 1'($urandom_range(0, 1));
      r = !w || 1'($urandom_range(0, 1));
      run_frame(w, r, 5'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0);
    end

    repeat (4) @(negedge clock);
    check("final_ready", ready, 1);
    check("final_mdc", mdc_pin, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
